proc_control: RTL and testbench

PROC_CONTROL -- requirements
Module: proc_control

---
 rtl/proc_control_if.sv | 39 +++
 rtl/proc_control.sv | 150 +++++++++++++++
 tb/tb_proc_control.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/proc_control_if.sv
// ---------------------------------------------------------------------------
// proc_control_if
//   Bus bundle between the proc_control sequencer and its environment.
//
//   Inputs to the sequencer (driven by master):
//     Run     start request, sampled only while idle (T0)
//     DIN     16-bit external data bus, DIN[8:0] is the instruction word
//   Outputs from the sequencer (driven by slave):
//     Select  one-hot bus-source select: bit9 DIN, bit8 G, bit7 R0 .. bit0 R7
//     Rin     register load enables, Rin[k] loads Rk
//     IRin    instruction-register load strobe
//     Ain     operand register A load strobe
//     Gin     result register G load strobe
//     AddSub  ALU operation, 0 = A+bus, 1 = A-bus
//     Done    single-cycle instruction-complete pulse
//     IR      current instruction register contents
// ---------------------------------------------------------------------------
interface proc_control_if;
    logic        Run;
    logic [15:0] DIN;
    logic [9:0]  Select;
    logic [7:0]  Rin;
    logic        IRin;
    logic        Ain;
    logic        Gin;
    logic        AddSub;
    logic        Done;
    logic [8:0]  IR;

    modport master (
        output Run, DIN,
        input  Select, Rin, IRin, Ain, Gin, AddSub, Done, IR
    );

    modport slave (
        input  Run, DIN,
        output Select, Rin, IRin, Ain, Gin, AddSub, Done, IR
    );
endinterface

// File: rtl/proc_control.sv
// ---------------------------------------------------------------------------
// proc_control
//   Control sequencer for a simple 8-register processor datapath.
//   A four-state machine (T0..T3) fetches a 9-bit instruction from DIN and
//   issues the bus-select and load strobes needed to execute it:
//     000 mv  Rx,Ry    T1: Select=Ry, Rin[x], Done
//     001 mvi Rx,#DIN  T1: Select=DIN, Rin[x], Done
//     010 add Rx,Ry    T1: Select=Rx, Ain  T2: Select=Ry, Gin  T3: Select=G, Rin[x], Done
//     011 sub Rx,Ry    as add, with AddSub=1 in T2
//     1xx reserved     T1: Done only
//
//   Ports:
//     Clock   rising-edge clock
//     Resetn  asynchronous active-low reset (state -> T0, IR -> 0)
//     bus     proc_control_if.slave: Run/DIN in, strobes/Select/IR out
//
//   Only the state and IR are registered; every strobe is decoded
//   combinationally from state, Run and IR so that IRin tracks Run in T0.
// ---------------------------------------------------------------------------
module proc_control (
    input  logic           Clock,
    input  logic           Resetn,
    proc_control_if.slave  bus
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_MV  = 3'b000,
        OP_MVI = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011
    } opcode_t;

    state_t     r_state;
    logic [8:0] r_ir;

    opcode_t    w_opcode;
    logic [2:0] w_rx;
    logic [2:0] w_ry;
    logic       w_is_alu;

    assign w_opcode = opcode_t'(r_ir[8:6]);
    assign w_rx     = r_ir[5:3];
    assign w_ry     = r_ir[2:0];
    assign w_is_alu = (w_opcode == OP_ADD) || (w_opcode == OP_SUB);

    // Register n drives Select bit (7-n): R0 on bit7 down to R7 on bit0.
    function automatic logic [9:0] f_reg_sel(input logic [2:0] n);
        return {2'b00, 8'h80 >> n};
    endfunction

    function automatic logic [7:0] f_rin(input logic [2:0] n);
        return 8'h01 << n;
    endfunction

    // -----------------------------------------------------------------------
    // State and instruction register
    // -----------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= T0;
            r_ir    <= '0;
        end else begin
            case (r_state)
                T0: begin
                    if (bus.Run) begin
                        r_ir    <= bus.DIN[8:0];
                        r_state <= T1;
                    end
                end
                T1: begin
                    r_state <= w_is_alu ? T2 : T0;
                end
                T2: begin
                    r_state <= T3;
                end
                T3: begin
                    r_state <= T0;
                end
                default: begin
                    r_state <= T0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output decode
    // -----------------------------------------------------------------------
    always_comb begin
        bus.Select = '0;
        bus.Rin    = '0;
        bus.IRin   = 1'b0;
        bus.Ain    = 1'b0;
        bus.Gin    = 1'b0;
        bus.AddSub = 1'b0;
        bus.Done   = 1'b0;

        case (r_state)
            T0: begin
                // Reset already forces T0; gating here keeps IRin low while
                // Resetn is held even if Run is high.
                bus.IRin = bus.Run & Resetn;
            end
            T1: begin
                case (w_opcode)
                    OP_MV: begin
                        bus.Select = f_reg_sel(w_ry);
                        bus.Rin    = f_rin(w_rx);
                        bus.Done   = 1'b1;
                    end
                    OP_MVI: begin
                        bus.Select = 10'b10_0000_0000;
                        bus.Rin    = f_rin(w_rx);
                        bus.Done   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        bus.Select = f_reg_sel(w_rx);
                        bus.Ain    = 1'b1;
                    end
                    default: begin
                        bus.Done = 1'b1;
                    end
                endcase
            end
            T2: begin
                bus.Select = f_reg_sel(w_ry);
                bus.Gin    = 1'b1;
                bus.AddSub = (w_opcode == OP_SUB);
            end
            T3: begin
                bus.Select = 10'b01_0000_0000;
                bus.Rin    = f_rin(w_rx);
                bus.Done   = 1'b1;
            end
            default: begin
                bus.Select = '0;
            end
        endcase
    end

    assign bus.IR = r_ir;

endmodule

// File: tb/tb_proc_control.sv
// ---------------------------------------------------------------------------
// tb_proc_control
//   Directed scoreboard bench for proc_control. The stimulus process drives
//   one cycle at a time (#1 after the rising edge) and queues the outputs that
//   cycle must show; the monitor pops and compares on every falling edge.
//   strobe vector order: {IRin, Ain, Gin, AddSub, Done}
// ---------------------------------------------------------------------------
module tb_proc_control;

    logic Clock;
    logic Resetn;

    proc_control_if bus();

    proc_control dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    typedef struct {
        string      nm;
        logic [9:0] sel;
        logic [7:0] rin;
        logic [4:0] stb;
        logic [8:0] ir;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Monitor: compare every presented cycle against the queued expectation.
    initial begin
        exp_t       e;
        logic [4:0] act_stb;
        forever begin
            @(negedge Clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                act_stb = {bus.IRin, bus.Ain, bus.Gin, bus.AddSub, bus.Done};
                n_tests++;
                if (bus.Select !== e.sel || bus.Rin !== e.rin ||
                    act_stb !== e.stb || bus.IR !== e.ir) begin
                    n_fail++;
                    $display("FAIL %s: got Select=%h Rin=%h stb=%b IR=%h, expected Select=%h Rin=%h stb=%b IR=%h",
                             e.nm, bus.Select, bus.Rin, act_stb, bus.IR,
                             e.sel, e.rin, e.stb, e.ir);
                end
            end
        end
    end

    task automatic step(input logic rstn, input logic run, input logic [15:0] din,
                        input string nm, input logic [9:0] sel, input logic [7:0] rin,
                        input logic [4:0] stb, input logic [8:0] ir);
        exp_t e;
        @(posedge Clock);
        #1;
        Resetn  = rstn;
        bus.Run = run;
        bus.DIN = din;
        e.nm  = nm;
        e.sel = sel;
        e.rin = rin;
        e.stb = stb;
        e.ir  = ir;
        q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Resetn  = 1'b0;
        bus.Run = 1'b1;
        bus.DIN = 16'h0048;

        // Reset held with Run high: everything 0, IRin suppressed
        step(0, 1, 16'h0048, "rst0",      10'h000, 8'h00, 5'b00000, 9'h000);
        step(0, 1, 16'h0048, "rst1",      10'h000, 8'h00, 5'b00000, 9'h000);
        step(1, 0, 16'h0000, "idle0",     10'h000, 8'h00, 5'b00000, 9'h000);

        // mvi R1,#0x1234 ; Run=1 in T1 ignored; DIN change outside T0 leaves IR
        step(1, 1, 16'h0048, "mvi_t0",    10'h000, 8'h00, 5'b10000, 9'h000);
        step(1, 1, 16'h1234, "mvi_t1",    10'h200, 8'h02, 5'b00001, 9'h048);
        step(1, 0, 16'h1234, "mvi_idle",  10'h000, 8'h00, 5'b00000, 9'h048);

        // mv R2,R1
        step(1, 1, 16'h0011, "mv_t0",     10'h000, 8'h00, 5'b10000, 9'h048);
        step(1, 0, 16'h0000, "mv_t1",     10'h040, 8'h04, 5'b00001, 9'h011);
        step(1, 0, 16'h0000, "mv_idle",   10'h000, 8'h00, 5'b00000, 9'h011);

        // sub R1,R2 with Run high during T1..T3
        step(1, 1, 16'h00CA, "sub_t0",    10'h000, 8'h00, 5'b10000, 9'h011);
        step(1, 1, 16'hFFFF, "sub_t1",    10'h040, 8'h00, 5'b01000, 9'h0CA);
        step(1, 1, 16'hFFFF, "sub_t2",    10'h020, 8'h00, 5'b00110, 9'h0CA);
        step(1, 1, 16'hFFFF, "sub_t3",    10'h100, 8'h02, 5'b00001, 9'h0CA);
        step(1, 0, 16'h0000, "sub_idle",  10'h000, 8'h00, 5'b00000, 9'h0CA);

        // reserved opcode 100
        step(1, 1, 16'h0100, "rsv4_t0",   10'h000, 8'h00, 5'b10000, 9'h0CA);
        step(1, 0, 16'h0000, "rsv4_t1",   10'h000, 8'h00, 5'b00001, 9'h100);
        step(1, 0, 16'h0000, "rsv4_idle", 10'h000, 8'h00, 5'b00000, 9'h100);

        // reserved opcode 111, upper DIN bits must not reach IR
        step(1, 1, 16'hFFC0, "rsv7_t0",   10'h000, 8'h00, 5'b10000, 9'h100);
        step(1, 0, 16'h0000, "rsv7_t1",   10'h000, 8'h00, 5'b00001, 9'h1C0);
        step(1, 0, 16'h0000, "rsv7_idle", 10'h000, 8'h00, 5'b00000, 9'h1C0);

        // mv R0,R7 (Select bit0, Rin bit0)
        step(1, 1, 16'h0007, "mv07_t0",   10'h000, 8'h00, 5'b10000, 9'h1C0);
        step(1, 0, 16'h0000, "mv07_t1",   10'h001, 8'h01, 5'b00001, 9'h007);
        step(1, 0, 16'h0000, "mv07_idle", 10'h000, 8'h00, 5'b00000, 9'h007);

        // sub R7,R6
        step(1, 1, 16'h00FE, "sub76_t0",  10'h000, 8'h00, 5'b10000, 9'h007);
        step(1, 0, 16'h0000, "sub76_t1",  10'h001, 8'h00, 5'b01000, 9'h0FE);
        step(1, 0, 16'h0000, "sub76_t2",  10'h002, 8'h00, 5'b00110, 9'h0FE);
        step(1, 0, 16'h0000, "sub76_t3",  10'h100, 8'h80, 5'b00001, 9'h0FE);
        step(1, 0, 16'h0000, "sub76_idle",10'h000, 8'h00, 5'b00000, 9'h0FE);

        // Back-to-back, Run held high: add R3,R3 then mv R7,R0
        step(1, 1, 16'h009B, "b2b_add_t0",10'h000, 8'h00, 5'b10000, 9'h0FE);
        step(1, 1, 16'h0038, "b2b_add_t1",10'h010, 8'h00, 5'b01000, 9'h09B);
        step(1, 1, 16'h0038, "b2b_add_t2",10'h010, 8'h00, 5'b00100, 9'h09B);
        step(1, 1, 16'h0038, "b2b_add_t3",10'h100, 8'h08, 5'b00001, 9'h09B);
        step(1, 1, 16'h0038, "b2b_mv_t0", 10'h000, 8'h00, 5'b10000, 9'h09B);
        step(1, 0, 16'h0000, "b2b_mv_t1", 10'h080, 8'h80, 5'b00001, 9'h038);
        step(1, 0, 16'h0000, "b2b_idle",  10'h000, 8'h00, 5'b00000, 9'h038);

        // add R0,R1 aborted by reset asserted part-way through T2
        step(1, 1, 16'h0081, "add_t0",    10'h000, 8'h00, 5'b10000, 9'h038);
        step(1, 0, 16'h0000, "add_t1",    10'h080, 8'h00, 5'b01000, 9'h081);
        step(0, 1, 16'h0081, "rst_in_t2", 10'h000, 8'h00, 5'b00000, 9'h000);
        step(0, 1, 16'h0081, "rst_hold",  10'h000, 8'h00, 5'b00000, 9'h000);
        step(1, 0, 16'h0081, "post_rst0", 10'h000, 8'h00, 5'b00000, 9'h000);
        step(1, 0, 16'h0081, "post_rst1", 10'h000, 8'h00, 5'b00000, 9'h000);
        step(1, 0, 16'h0081, "post_rst2", 10'h000, 8'h00, 5'b00000, 9'h000);

        // fresh instruction after reset
        step(1, 1, 16'h0011, "fresh_t0",  10'h000, 8'h00, 5'b10000, 9'h000);
        step(1, 0, 16'h0000, "fresh_t1",  10'h040, 8'h04, 5'b00001, 9'h011);
        step(1, 0, 16'h0000, "fresh_idle",10'h000, 8'h00, 5'b00000, 9'h011);

        repeat (3) @(negedge Clock);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
